// File: rtl/register16.sv
// 16-bit datapath storage register: synchronous active-low reset, write enable,
// output driven straight from the flop with no combinational path from in to out.
module register16 #(
  parameter int unsigned          WIDTH       = 16,
  parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             RegWrite,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  // Reset takes priority over a write on the same edge.
  always_comb begin
    data_d = data_q;
    if (!RST_n) begin
      data_d = RESET_VALUE;
    end else if (RegWrite) begin
      data_d = in;
    end
  end

  always_ff @(posedge CLK) begin
    data_q <= data_d;
  end

  assign out = data_q;

endmodule

// File: tb/tb_register16.sv
// Self-checking bench for register16: directed scenarios plus randomized traffic
// compared against a simple behavioural model of the stored word.
module tb_register16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        reg_write;
  logic [15:0] din;
  logic [15:0] dout;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] model;
  bit          ramp_done;

  always #10 clk = ~clk;

  register16 #(
    .WIDTH      (16),
    .RESET_VALUE(16'h0000)
  ) u_dut (
    .CLK     (clk),
    .RST_n   (rst_n),
    .RegWrite(reg_write),
    .in      (din),
    .out     (dout)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: out=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one edge worth of inputs, update the model from the rules, check 1 ns later.
  task automatic cycle(input logic r, input logic w, input logic [15:0] d, input string tag);
    rst_n     = r;
    reg_write = w;
    din       = d;
    @(posedge clk);
    if (!r)     model = 16'h0000;
    else if (w) model = d;
    #1;
    check(tag, dout, model);
  endtask

  initial begin
    logic r, w;
    logic [15:0] d;
    model = 'x;

    // Reset beats write
    cycle(1'b0, 1'b1, 16'hBEEF, "reset_wins");

    // Basic write; before the edge out still shows prior value
    rst_n = 1'b1; reg_write = 1'b1; din = 16'd20;
    #5 check("pre_edge_prior", dout, 16'h0000);
    @(posedge clk); model = 16'd20; #1 check("basic_write", dout, 16'd20);

    // Hold for 3 edges, then write
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 16'h1234, "hold");
    cycle(1'b1, 1'b1, 16'h1234, "write_after_hold");

    // Full width, back-to-back
    cycle(1'b1, 1'b1, 16'hFFFF, "full_ffff");
    cycle(1'b1, 1'b1, 16'h0000, "full_0000");
    cycle(1'b1, 1'b1, 16'hA5A5, "full_a5a5");

    // Mid-stream reset then release
    cycle(1'b1, 1'b1, 16'h00C8, "pre_midreset");
    cycle(1'b0, 1'b1, 16'h00DC, "midreset");
    cycle(1'b1, 1'b1, 16'h00DC, "release_capture");

    // Between-edge activity must not reach out
    cycle(1'b1, 1'b1, 16'h1111, "mid_setup");
    din = 16'h2222; #3;
    rst_n = 1'b0; #3;
    check("between_edges_in", dout, 16'h1111);
    rst_n = 1'b1; din = 16'h3333; #3;
    check("between_edges_rst", dout, 16'h1111);
    @(posedge clk); model = 16'h3333; #1 check("edge_captures_last", dout, 16'h3333);

    // Ramp: in steps +20 every 30 ns, kept off the clock edges
    @(negedge clk); #5;
    reg_write = 1'b1; rst_n = 1'b1; ramp_done = 1'b0;
    fork
      begin
        for (int v = 20; v <= 600; v += 20) begin
          din = 16'(v);
          #30;
        end
        ramp_done = 1'b1;
      end
      begin
        while (!ramp_done) begin
          @(posedge clk);
          model = din;
          #1 check("ramp", dout, model);
        end
      end
    join

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      r = ($urandom_range(0, 15) != 0);
      w = 1'($urandom_range(0, 1));
      d = 16'($urandom);
      cycle(r, w, d, "random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
